vram_axis_reader: RTL and testbench

Read side of the 64x9216 accumulation VRAM. On each frame request it scans all 96x96 pixel addresses and normalises each 64-bit signed accumulated power value to 8 bits, using the peak of the previous frame. It emits the result as an AXI4-Stream video frame (grey replicated to 24-bit RGB) toward the VDMA S2MM path.

---
 rtl/vram_pkg.sv | 38 +++
 rtl/sync_fifo.sv | 52 +++++
 rtl/vram_axis_reader.sv | 166 ++++++++++++++++
 tb/tb_vram_axis_reader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared VRAM geometry, pixel and FSM types, and the peak-to-shift helpers
// used by the accumulation VRAM read path.
package vram_pkg;

    localparam int unsigned VRAM_DEPTH = 9216;
    localparam int unsigned VRAM_AW    = 14;
    localparam int unsigned VRAM_DW    = 64;

    typedef logic [7:0] pixel_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN
    } state_t;

    // Index of the highest set bit; 0 for a zero input.
    function automatic logic [5:0] msb_index(input logic [63:0] v);
        logic [5:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (v[i]) idx = 6'(i);
        end
        return idx;
    endfunction

    // Shift that maps the previous peak onto the top of the 8-bit range.
    function automatic logic [5:0] shift_for_peak(input logic [63:0] p);
        logic [5:0] m;
        m = msb_index(p);
        return (m >= 6'd7) ? (m - 6'd7) : 6'd0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vram_axis_reader.sv
// Scans the accumulation VRAM once per frame request, normalises each value
// against the previous frame's peak and streams it out as AXIS grey video.
module vram_axis_reader
    import vram_pkg::*;
#(
    parameter int unsigned H_ACT      = 96,
    parameter int unsigned V_ACT      = 96,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               Aclk,
    input  logic               rst,
    input  logic               frame_start,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic [VRAM_DW-1:0] vram_data,
    output logic [23:0]        m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tuser,
    output logic               m_axis_tlast,
    output logic               busy,
    output logic               frame_done,
    output logic [VRAM_DW-1:0] peak
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned XW = $clog2(H_ACT);
    localparam int unsigned YW = $clog2(V_ACT);
    localparam logic [VRAM_AW:0] NPIX  = (VRAM_AW+1)'(H_ACT * V_ACT);
    localparam logic [XW-1:0]    XLAST = XW'(H_ACT - 1);
    localparam logic [YW-1:0]    YLAST = YW'(V_ACT - 1);

    state_t             state;
    logic [VRAM_AW:0]   rd_cnt;
    logic [VRAM_AW-1:0] addr_q;
    logic [RD_LAT-1:0]  tag;
    logic [5:0]         shift;
    logic [VRAM_DW-1:0] running_max;
    logic [XW-1:0]      x;
    logic [YW-1:0]      y;

    logic [CW-1:0]      inflight;
    logic [CW-1:0]      fifo_count;
    logic [CW:0]        pending;
    logic               fifo_full;
    logic               fifo_empty;
    pixel_t             fifo_out;

    logic               issue;
    logic               ret_valid;
    logic               hs;
    logic               last_hs;
    logic [VRAM_DW-1:0] clamped;
    logic [VRAM_DW-1:0] scaled;
    logic [VRAM_DW-1:0] frame_max;
    pixel_t             g;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(tag[i]);
        end
    end

    // Credits cover both the read pipeline and the FIFO, so a push never finds it full.
    assign pending   = {1'b0, inflight} + {1'b0, fifo_count};
    assign issue     = (state == RUN) && (rd_cnt < NPIX) && !fifo_full &&
                       (pending < (CW+1)'(FIFO_DEPTH));
    assign ret_valid = tag[RD_LAT-1];

    assign clamped   = vram_data[VRAM_DW-1] ? '0 : vram_data;
    assign scaled    = clamped >> shift;
    assign g         = (|scaled[VRAM_DW-1:8]) ? 8'hFF : scaled[7:0];
    assign frame_max = (ret_valid && (clamped > running_max)) ? clamped : running_max;

    assign hs      = m_axis_tvalid && m_axis_tready;
    assign last_hs = hs && (x == XLAST) && (y == YLAST);

    assign vram_addr     = addr_q;
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = {fifo_out, fifo_out, fifo_out};
    assign m_axis_tuser  = m_axis_tvalid && (x == '0) && (y == '0);
    assign m_axis_tlast  = m_axis_tvalid && (x == XLAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (Aclk),
        .rst     (rst),
        .wr_en   (ret_valid),
        .wr_data (g),
        .rd_en   (hs),
        .rd_data (fifo_out),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge Aclk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rd_cnt      <= '0;
            addr_q      <= '0;
            tag         <= '0;
            shift       <= '0;
            running_max <= '0;
            peak        <= '0;
            x           <= '0;
            y           <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= last_hs;

            tag[0] <= issue;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag[i] <= tag[i-1];
            end

            if (ret_valid) running_max <= frame_max;

            if (hs) begin
                if (x == XLAST) begin
                    x <= '0;
                    y <= (y == YLAST) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end

            // Address holds at the final pixel once the scan is complete.
            if (issue) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_cnt != NPIX - 1'b1) addr_q <= addr_q + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state       <= RUN;
                        rd_cnt      <= '0;
                        addr_q      <= '0;
                        running_max <= '0;
                        x           <= '0;
                        y           <= '0;
                        shift       <= shift_for_peak(peak);
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    if (rd_cnt == NPIX) state <= DRAIN;
                end
                DRAIN: begin
                    if (last_hs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        peak  <= frame_max;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_axis_reader.sv
// Randomised scoreboard bench for vram_axis_reader: a behavioural VRAM,
// a per-frame expectation queue and an independent AXIS monitor.
module tb_vram_axis_reader;

    localparam int H    = 96;
    localparam int V    = 96;
    localparam int NPIX = H * V;
    localparam int LAT  = 2;

    typedef struct packed {
        logic [7:0] g;
        logic       user;
        logic       last;
    } beat_t;

    logic        Aclk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [13:0] vram_addr;
    logic [63:0] vram_data;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        busy;
    logic        frame_done;
    logic [63:0] peak;

    logic [63:0] mem [NPIX];
    logic [63:0] d1, d2;
    beat_t       exp_q[$];
    logic [63:0] model_peak = '0;
    bit          rand_ready = 1'b0;
    bit          prev_stall = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          done_count = 0;

    always #5 Aclk = ~Aclk;

    vram_axis_reader #(
        .H_ACT      (H),
        .V_ACT      (V),
        .RD_LAT     (LAT),
        .FIFO_DEPTH (4)
    ) dut (
        .Aclk          (Aclk),
        .rst           (rst),
        .frame_start   (frame_start),
        .vram_addr     (vram_addr),
        .vram_data     (vram_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .frame_done    (frame_done),
        .peak          (peak)
    );

    // Two-stage synchronous read port: data appears two cycles after the address.
    always @(posedge Aclk) begin
        d1 <= mem[vram_addr];
        d2 <= d1;
    end
    assign vram_data = d2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected frame from the rules: clamp, scale so the old peak fits 8 bits, saturate.
    task automatic expect_frame(output logic [63:0] new_peak);
        int unsigned sh;
        logic [63:0] p, c, gv;
        beat_t b;
        p  = model_peak;
        sh = 0;
        while (p > 64'd255) begin
            p = p >> 1;
            sh++;
        end
        new_peak = '0;
        for (int i = 0; i < NPIX; i++) begin
            c = ($signed(mem[i]) < 0) ? 64'd0 : mem[i];
            if (c > new_peak) new_peak = c;
            gv = c >> sh;
            if (gv > 64'd255) gv = 64'd255;
            b.g    = gv[7:0];
            b.user = (i == 0);
            b.last = ((i % H) == H - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic run_frame(input int abort_beat, input bit inject, input bit timing);
        logic [63:0] np;
        int cyc, beats, first_valid, done_cyc;
        expect_frame(np);
        @(posedge Aclk); #1 frame_start = 1'b1;
        @(posedge Aclk); #1 frame_start = 1'b0;
        cyc = 1; beats = 0; first_valid = -1; done_cyc = -1;
        if (timing) check("busy_rise", busy, 1);
        while (done_cyc < 0 && cyc < 60000) begin
            @(negedge Aclk);
            if (m_axis_tvalid && first_valid < 0) first_valid = cyc;
            if (frame_done) done_cyc = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                if (beats == abort_beat) begin
                    rst = 1'b1;
                    #1;
                    check("rst_tvalid", m_axis_tvalid, 0);
                    check("rst_tuser", m_axis_tuser, 0);
                    check("rst_tlast", m_axis_tlast, 0);
                    check("rst_busy", busy, 0);
                    check("rst_done", frame_done, 0);
                    check("rst_peak", peak, 0);
                    check("rst_addr", vram_addr, 0);
                    exp_q.delete();
                    model_peak = '0;
                    return;
                end
                if (inject && beats == NPIX - 1) frame_start = 1'b1;
                beats++;
            end
            if (inject && cyc == 100) frame_start = 1'b1;
            @(posedge Aclk); #1 frame_start = 1'b0;
            cyc++;
        end
        if (done_cyc < 0) begin
            check("frame_timeout", 0, 1);
        end else begin
            check("peak", peak, np);
            check("beat_count", beats, NPIX);
            check("queue_drained", exp_q.size(), 0);
            check("busy_fall", busy, 0);
            if (timing) begin
                check("first_valid_lat", first_valid, LAT + 2);
                check("frame_cycles", done_cyc, NPIX + LAT + 2);
            end
        end
        model_peak = np;
    endtask

    // Monitor: every presented beat (stalled or not) must equal the queue head.
    always @(negedge Aclk) begin
        beat_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (frame_done) done_count++;
            if (prev_stall) check("stall_valid_hold", m_axis_tvalid, 1);
            if (m_axis_tvalid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q[0];
                    check("tdata", m_axis_tdata, {e.g, e.g, e.g});
                    check("tuser", m_axis_tuser, e.user);
                    check("tlast", m_axis_tlast, e.last);
                    if (m_axis_tready) void'(exp_q.pop_front());
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
        end
    end

    initial begin
        forever begin
            @(posedge Aclk); #1;
            m_axis_tready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    initial begin
        bit extra;
        logic [63:0] r;

        for (int i = 0; i < NPIX; i++) mem[i] = 64'(i);
        #23;
        check("reset_tvalid", m_axis_tvalid, 0);
        check("reset_busy", busy, 0);
        check("reset_peak", peak, 0);
        check("reset_addr", vram_addr, 0);
        check("reset_done", frame_done, 0);
        @(negedge Aclk); rst = 1'b0;

        // Identity contents, shift 0, then shift 6 from peak 9215.
        run_frame(-1, 1'b0, 1'b1);
        run_frame(-1, 1'b0, 1'b0);

        // Negative entry clamps; extra requests while busy and at the last beat are ignored.
        for (int i = 0; i < NPIX; i++) mem[i] = 64'h10;
        mem[5] = -64'sd1000;
        run_frame(-1, 1'b1, 1'b0);
        extra = 1'b0;
        repeat (20) begin
            @(negedge Aclk);
            if (m_axis_tvalid || busy) extra = 1'b1;
        end
        check("no_second_frame", extra, 0);

        // Random contents under 30% ready duty.
        for (int i = 0; i < NPIX; i++) begin
            r = {$urandom(), $urandom()};
            r = r >> $urandom_range(0, 62);
            if ($urandom_range(0, 3) == 0) r = -r;
            mem[i] = r;
        end
        rand_ready = 1'b1;
        run_frame(-1, 1'b0, 1'b0);
        rand_ready = 1'b0;

        // Reset mid-frame, then a clean frame from a zero peak.
        for (int i = 0; i < NPIX; i++) mem[i] = 64'(i);
        run_frame(4000, 1'b0, 1'b0);
        repeat (3) @(negedge Aclk);
        rst = 1'b0;
        check("peak_after_reset", peak, 0);
        run_frame(-1, 1'b0, 1'b0);

        repeat (5) @(negedge Aclk);
        check("frame_done_pulses", done_count, 5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
